// File: rtl/btn_pkg.sv
`default_nettype none
// ============================================================================
// Module      : btn_pkg
// Description : Shared types and elaboration helpers for the button
//               debounce bank (channel state encoding, ms-to-cycle math).
// Revision    : 1.0 - initial release
// ============================================================================
package btn_pkg;

  // Per-channel debounce state
  typedef enum logic [1:0] {
    S_LOW    = 2'd0,
    S_WAIT_H = 2'd1,
    S_HIGH   = 2'd2,
    S_WAIT_L = 2'd3
  } btn_state_t;

  // Number of clock cycles in a millisecond interval
  function automatic int ms_to_cycles(input int clk_hz, input int ms);
    return (clk_hz / 1000) * ms;
  endfunction

  // Larger of two integers, used for counter sizing
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage : btn_pkg
`default_nettype wire

// File: rtl/btn_debounce_ch.sv
`default_nettype none
// ============================================================================
// Module      : btn_debounce_ch
// Description : One button channel: 2-FF synchronizer, debounce FSM with a
//               saturating stability counter, registered level and
//               one-cycle press/release pulses. With BTN_LONG_PRESS_EN
//               defined, the counter is reused in S_HIGH to emit a single
//               long-press pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module btn_debounce_ch
  import btn_pkg::*;
#(
  parameter int DB_CYCLES   = 4,
`ifdef BTN_LONG_PRESS_EN
  parameter int LONG_CYCLES = 10,
`endif
  parameter int CW          = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o,
  output logic long_o
);

  localparam logic [CW-1:0] C_DB_LAST = CW'(DB_CYCLES - 1);
  localparam logic [CW-1:0] C_ONE     = CW'(1);
`ifdef BTN_LONG_PRESS_EN
  localparam logic [CW-1:0] C_LONG_LAST = CW'(LONG_CYCLES - 1);
  localparam logic [CW-1:0] C_LONG_DONE = CW'(LONG_CYCLES);
`endif

  logic          s1_q, s2_q;
  btn_state_t    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          rise_q, rise_d;
  logic          fall_q, fall_d;

  // Two-flop synchronizer for the asynchronous pin level
  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= raw_i;
      s2_q <= s1_q;
    end
  end

`ifdef BTN_LONG_PRESS_EN
  logic long_q, long_d;
`endif

  // Next-state logic: a level change is accepted only after s2 has held the
  // new value for DB_CYCLES further cycles; any reversion restarts it.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
`ifdef BTN_LONG_PRESS_EN
    long_d  = 1'b0;
`endif
    unique case (state_q)
      S_LOW: begin
        if (s2_q) begin
          state_d = S_WAIT_H;
          cnt_d   = '0;
        end
      end
      S_WAIT_H: begin
        if (!s2_q) begin
          state_d = S_LOW;
        end else if (cnt_q == C_DB_LAST) begin
          state_d = S_HIGH;
          level_d = 1'b1;
          rise_d  = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + C_ONE;
        end
      end
      S_HIGH: begin
        if (!s2_q) begin
          state_d = S_WAIT_L;
          cnt_d   = '0;
        end else begin
`ifdef BTN_LONG_PRESS_EN
          // Count hold time once; parking at C_LONG_DONE prevents repeats
          if (cnt_q != C_LONG_DONE) begin
            cnt_d = cnt_q + C_ONE;
          end
          if (cnt_q == C_LONG_LAST) begin
            long_d = 1'b1;
          end
`endif
        end
      end
      S_WAIT_L: begin
        if (s2_q) begin
          // Release bounce rejected; hold timing restarts on re-entry
          state_d = S_HIGH;
          cnt_d   = '0;
        end else if (cnt_q == C_DB_LAST) begin
          state_d = S_LOW;
          level_d = 1'b0;
          fall_d  = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + C_ONE;
        end
      end
      default: begin
        state_d = S_LOW;
        cnt_d   = '0;
      end
    endcase
  end

  // State, counter and registered outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_LOW;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
`ifdef BTN_LONG_PRESS_EN
      long_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
`ifdef BTN_LONG_PRESS_EN
      long_q  <= long_d;
`endif
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;
`ifdef BTN_LONG_PRESS_EN
  assign long_o  = long_q;
`else
  assign long_o  = 1'b0;
`endif

endmodule : btn_debounce_ch
`default_nettype wire

// File: rtl/btn_debounce_bank.sv
`default_nettype none
// ============================================================================
// Module      : btn_debounce_bank
// Description : N independent push-button conditioning channels feeding the
//               reaction-test controller. Wiring only; all logic lives in
//               btn_debounce_ch. Optional feature macro: BTN_LONG_PRESS_EN
//               (enables btn_long_o; port list is identical either way).
// Revision    : 1.0 - initial release
// ============================================================================
module btn_debounce_bank
  import btn_pkg::*;
#(
  parameter int N_BTN       = 4,
  parameter int CLK_HZ      = 100_000_000,
  parameter int DEBOUNCE_MS = 20,
  parameter int LONG_MS     = 1000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_raw_i,
  output logic [N_BTN-1:0] btn_level_o,
  output logic [N_BTN-1:0] btn_rise_o,
  output logic [N_BTN-1:0] btn_fall_o,
  output logic [N_BTN-1:0] btn_long_o
);

  localparam int DB_CYCLES   = ms_to_cycles(CLK_HZ, DEBOUNCE_MS);
  localparam int LONG_CYCLES = ms_to_cycles(CLK_HZ, LONG_MS);
  localparam int CW          = $clog2(max_int(DB_CYCLES, LONG_CYCLES) + 1);

  // A one-cycle debounce window would make the counter compare degenerate
  if (DB_CYCLES < 2) begin : g_cfg_error
    $error("btn_debounce_bank: DB_CYCLES=%0d must be >= 2", DB_CYCLES);
  end

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    btn_debounce_ch #(
      .DB_CYCLES   (DB_CYCLES),
`ifdef BTN_LONG_PRESS_EN
      .LONG_CYCLES (LONG_CYCLES),
`endif
      .CW          (CW)
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .raw_i   (btn_raw_i[i]),
      .level_o (btn_level_o[i]),
      .rise_o  (btn_rise_o[i]),
      .fall_o  (btn_fall_o[i]),
      .long_o  (btn_long_o[i])
    );
  end

endmodule : btn_debounce_bank
`default_nettype wire

// File: tb/tb_btn_debounce_bank.sv
`default_nettype none
// ============================================================================
// Module      : tb_btn_debounce_bank
// Description : Directed scenarios plus randomized toggling/reset traffic for
//               btn_debounce_bank, compared every cycle against a run-length
//               reference model of the debounce rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_btn_debounce_bank;

  localparam int N    = 4;
  localparam int DB   = (1000 / 1000) * 4;   // CLK_HZ=1000, DEBOUNCE_MS=4
  localparam int LONG = (1000 / 1000) * 10;  // LONG_MS=10
`ifdef BTN_LONG_PRESS_EN
  localparam bit LONG_EN = 1'b1;
`else
  localparam bit LONG_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [N-1:0] raw = '0;
  logic [N-1:0] level, rise, fall, lng;

  btn_debounce_bank #(
    .N_BTN       (N),
    .CLK_HZ      (1000),
    .DEBOUNCE_MS (4),
    .LONG_MS     (10)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .btn_raw_i   (raw),
    .btn_level_o (level),
    .btn_rise_o  (rise),
    .btn_fall_o  (fall),
    .btn_long_o  (lng)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: pipeline delay of two samples, then a run-length rule:
  // the level flips once the delayed input has disagreed with it for DB+1
  // consecutive samples. Hold time counts samples spent settled high.
  logic         m_s1 [N];
  logic         m_s2 [N];
  logic         m_lvl[N];
  int           m_run [N];
  int           m_hold[N];
  logic [N-1:0] e_level = '0, e_rise = '0, e_fall = '0, e_long = '0;

  task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_edge();
    for (int c = 0; c < N; c++) begin
      bit was_high;
      bit now_high;
      e_rise[c] = 1'b0;
      e_fall[c] = 1'b0;
      e_long[c] = 1'b0;
      if (!rst) begin
        m_s1[c]   = 1'b0;
        m_s2[c]   = 1'b0;
        m_lvl[c]  = 1'b0;
        m_run[c]  = 0;
        m_hold[c] = 0;
      end else begin
        was_high = m_lvl[c] && (m_run[c] == 0);
        if (m_s2[c] != m_lvl[c]) begin
          m_run[c]++;
          if (m_run[c] == DB + 1) begin
            m_lvl[c]  = m_s2[c];
            e_rise[c] = m_s2[c];
            e_fall[c] = !m_s2[c];
            m_run[c]  = 0;
          end
        end else begin
          m_run[c] = 0;
        end
        now_high = m_lvl[c] && (m_run[c] == 0);
        if (now_high && was_high) begin
          if (m_hold[c] <= LONG) m_hold[c]++;
          if (m_hold[c] == LONG && LONG_EN) e_long[c] = 1'b1;
        end else begin
          m_hold[c] = 0;
        end
        m_s2[c] = m_s1[c];
        m_s1[c] = raw[c];
      end
      e_level[c] = m_lvl[c];
    end
  endtask

  // One clock: advance the model with the inputs the DUT samples, then compare
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check("level", level, e_level);
    check("rise",  rise,  e_rise);
    check("fall",  fall,  e_fall);
    check("long",  lng,   e_long);
  endtask

  // Edges from the next clock until a pulse appears; -1 if none within budget
  task automatic wait_pulse(input int ch, input bit want_rise, output int n);
    n = -1;
    for (int k = 0; k < 50; k++) begin
      tick();
      if ((want_rise ? rise[ch] : fall[ch]) === 1'b1) begin
        n = k;
        break;
      end
    end
  endtask

  initial begin
    int n;
    int pulses;
    int first;

    // Reset state
    rst = 1'b0;
    raw = '0;
    repeat (3) tick();
    check("reset_outputs", level | rise | fall | lng, 4'b0000);
    rst = 1'b1;
    repeat (2) tick();

    // 1. Clean press on channel 0
    raw[0] = 1'b1;
    wait_pulse(0, 1'b1, n);
    check_int("press_latency", n, DB + 2);
    repeat (14) tick();
    check("press_level", level, 4'b0001);

    // 2. Bouncing press on channel 1
    raw[1] = 1'b1; repeat (3) tick();
    raw[1] = 1'b0; tick();
    raw[1] = 1'b1; repeat (2) tick();
    raw[1] = 1'b0; tick();
    raw[1] = 1'b1;
    wait_pulse(1, 1'b1, n);
    check_int("bounce_latency", n, DB + 2);

    // 3. Release of channel 0
    raw[0] = 1'b0;
    wait_pulse(0, 1'b0, n);
    check_int("release_latency", n, DB + 2);
    check("release_level", level, 4'b0010);

    // 4. Reset in the middle of a channel 2 debounce count
    raw[2] = 1'b1;
    repeat (5) tick();
    rst = 1'b0;
    tick();
    check("midreset_outputs", level | rise | fall | lng, 4'b0000);
    rst = 1'b1;
    wait_pulse(2, 1'b1, n);
    check_int("post_reset_latency", n, DB + 2);

    // 5. Simultaneous press on channels 0 and 3
    raw = '0;
    repeat (12) tick();
    raw = 4'b1001;
    wait_pulse(0, 1'b1, n);
    check_int("simul_latency", n, DB + 2);
    check("simul_rise", rise, 4'b1001);

    // 6. Long hold on channel 0
    raw = '0;
    repeat (12) tick();
    raw[0] = 1'b1;
    wait_pulse(0, 1'b1, n);
    pulses = 0;
    first  = -1;
    for (int j = 1; j <= 40; j++) begin
      tick();
      if (lng[0] === 1'b1) begin
        pulses++;
        if (first < 0) first = j;
      end
    end
    check_int("long_pulses", pulses, LONG_EN ? 1 : 0);
    check_int("long_offset", first, LONG_EN ? LONG : -1);

    // Randomized traffic: fast bounce, mid-rate and slow toggling, rare resets
    raw = '0;
    for (int seg = 0; seg < 3; seg++) begin
      int rate;
      rate = (seg == 0) ? 3 : (seg == 1) ? 10 : 40;
      repeat (200) begin
        for (int c = 0; c < N; c++) begin
          if ($urandom_range(rate - 1) == 0) raw[c] = ~raw[c];
        end
        rst = ($urandom_range(149) == 0) ? 1'b0 : 1'b1;
        tick();
      end
    end
    rst = 1'b1;
    repeat (10) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_btn_debounce_bank
`default_nettype wire
